// File: rtl/display_scan_mux_pkg.sv
// Shared definitions for the display scan multiplexer.
//   DEF_WIDTH / DEF_NCH : default code width and channel count
//   MAX_CH              : widest one-hot vector onehot() can produce
//   onehot(idx, n)      : one-hot of idx within n channels (all-0 if idx >= n)
package disp_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned MAX_CH    = 32;

  function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_CH-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (i == idx && i < n) begin
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/display_scan_mux_prescaler.sv
// Scan prescaler: modulo-SCAN_DIV counter that advances only while enabled.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   en    : count enable; count holds while low
//   tick  : combinational, high in the last enabled cycle of each slot
module scan_prescaler #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  // Keep at least one bit so SCAN_DIV = 1 still elaborates; the count then stays at 0.
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == CW'(SCAN_DIV - 1));

  always_comb begin
    count_d = count_q;
    if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed N_CH:1 channel selector for the stopwatch 7-segment display.
// Digit codes are captured into a shadow register on load and scanned round-robin,
// one slot every SCAN_DIV enabled cycles.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high
//   en         : scan enable; low freezes the scan and darks the display
//   load       : 1-cycle strobe copying data_in into the shadow register
//   data_in    : channel k at [k*WIDTH +: WIDTH]
//   blank_mask : 1 = channel k blanked, sampled when a slot starts
//   y          : registered code of the current slot (0 when blanked/dark)
//   sel        : registered index of the current slot
//   digit_en   : registered one-hot digit enable (all-0 when blanked/dark)
//   slot_tick  : registered pulse, high the cycle the outputs change slot
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned N_CH     = DEF_NCH,   // 2..MAX_CH
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     load,
  input  logic [N_CH*WIDTH-1:0]    data_in,
  input  logic [N_CH-1:0]          blank_mask,
  output logic [WIDTH-1:0]         y,
  output logic [$clog2(N_CH)-1:0]  sel,
  output logic [N_CH-1:0]          digit_en,
  output logic                     slot_tick
);

  localparam int unsigned SELW = $clog2(N_CH);

  logic                        tick;
  logic [N_CH-1:0][WIDTH-1:0]  shadow_q;
  logic [SELW-1:0]             slot_q, slot_next;
  logic [MAX_CH-1:0]           oh_full;
  logic                        unused_oh_full;

  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]  digit_en_q, digit_en_d;
  logic             slot_tick_q, slot_tick_d;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  // Explicit wrap keeps non-power-of-2 channel counts inside 0..N_CH-1.
  assign slot_next = (slot_q == SELW'(N_CH - 1)) ? '0 : slot_q + 1'b1;

  // Only the low N_CH bits drive digit_en.
  assign oh_full        = onehot(32'(slot_next), N_CH);
  assign unused_oh_full = ^oh_full;

  always_comb begin
    y_d         = y_q;
    sel_d       = sel_q;
    digit_en_d  = digit_en_q;
    slot_tick_d = 1'b0;
    if (!en) begin
      // Display goes dark but sel keeps pointing at the frozen slot.
      y_d        = '0;
      digit_en_d = '0;
    end else if (tick) begin
      sel_d       = slot_next;
      slot_tick_d = 1'b1;
      if (blank_mask[slot_next]) begin
        y_d        = '0;
        digit_en_d = '0;
      end else begin
        y_d        = shadow_q[slot_next];
        digit_en_d = oh_full[N_CH-1:0];
      end
    end
  end

  // Shadow loads regardless of en; a coincident tick still reads the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (load) begin
      shadow_q <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else if (tick) begin
      slot_q <= slot_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q         <= '0;
      sel_q       <= '0;
      digit_en_q  <= '0;
      slot_tick_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      sel_q       <= sel_d;
      digit_en_q  <= digit_en_d;
      slot_tick_q <= slot_tick_d;
    end
  end

  assign y         = y_q;
  assign sel       = sel_q;
  assign digit_en  = digit_en_q;
  assign slot_tick = slot_tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: a 4-channel/SCAN_DIV=3 instance for the main
// scenarios and a 3-channel/SCAN_DIV=1 instance for the non-power-of-2 wrap.
module tb_display_scan_mux;

  logic clk;

  // 4-channel instance
  logic        reset, en, load;
  logic [15:0] data_in;
  logic [3:0]  blank_mask;
  logic [3:0]  y;
  logic [1:0]  sel;
  logic [3:0]  digit_en;
  logic        slot_tick;

  // 3-channel instance
  logic        reset3, en3, load3;
  logic [11:0] data_in3;
  logic [2:0]  blank_mask3;
  logic [3:0]  y3;
  logic [1:0]  sel3;
  logic [2:0]  digit_en3;
  logic        slot_tick3;

  int vectors     = 0;
  int miscompares = 0;

  display_scan_mux #(
    .WIDTH    (4),
    .N_CH     (4),
    .SCAN_DIV (3)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .blank_mask (blank_mask),
    .y          (y),
    .sel        (sel),
    .digit_en   (digit_en),
    .slot_tick  (slot_tick)
  );

  display_scan_mux #(
    .WIDTH    (4),
    .N_CH     (3),
    .SCAN_DIV (1)
  ) u_dut3 (
    .clk        (clk),
    .reset      (reset3),
    .en         (en3),
    .load       (load3),
    .data_in    (data_in3),
    .blank_mask (blank_mask3),
    .y          (y3),
    .sel        (sel3),
    .digit_en   (digit_en3),
    .slot_tick  (slot_tick3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] e_sel, input logic [3:0] e_y,
                         input logic [3:0] e_en, input logic e_tick);
    check({tag, ".sel"}, 32'(sel), 32'(e_sel));
    check({tag, ".y"}, 32'(y), 32'(e_y));
    check({tag, ".digit_en"}, 32'(digit_en), 32'(e_en));
    check({tag, ".slot_tick"}, 32'(slot_tick), 32'(e_tick));
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int          exp_s[6] = '{1, 2, 0, 1, 2, 0};
  int          exp_y[6] = '{0, 3, 1, 2, 3, 1};
  logic [2:0]  e_oh3;

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; data_in = '0; blank_mask = '0;
    reset3 = 1'b1; en3 = 1'b0; load3 = 1'b0; data_in3 = '0; blank_mask3 = '0;
    step(2);
    chk_out("reset", 2'd0, 4'h0, 4'b0000, 1'b0);
    check("reset3.sel", 32'(sel3), 32'd0);
    check("reset3.digit_en", 32'(digit_en3), 32'd0);

    // Basic scan: first tick three enabled cycles after release selects slot 1.
    reset = 1'b0; en = 1'b1; load = 1'b1; data_in = 16'h4321;
    step(1);
    load = 1'b0;
    step(1);
    chk_out("pre_tick", 2'd0, 4'h0, 4'b0000, 1'b0);
    step(1);
    chk_out("scan1", 2'd1, 4'h2, 4'b0010, 1'b1);
    step(1);
    chk_out("scan1_hold", 2'd1, 4'h2, 4'b0010, 1'b0);
    step(2);
    chk_out("scan2", 2'd2, 4'h3, 4'b0100, 1'b1);
    step(3);
    chk_out("scan3", 2'd3, 4'h4, 4'b1000, 1'b1);
    step(3);
    chk_out("scan0", 2'd0, 4'h1, 4'b0001, 1'b1);

    // Blanking of channel 2 only.
    blank_mask = 4'b0100;
    step(3);
    chk_out("blank_s1", 2'd1, 4'h2, 4'b0010, 1'b1);
    step(3);
    chk_out("blank_s2", 2'd2, 4'h0, 4'b0000, 1'b1);
    step(3);
    chk_out("blank_s3", 2'd3, 4'h4, 4'b1000, 1'b1);
    blank_mask = 4'b0000;
    step(3);
    chk_out("blank_s0", 2'd0, 4'h1, 4'b0001, 1'b1);

    // Load coincident with a tick: slot 1 shows old code, slot 2 the new one.
    step(2);
    load = 1'b1; data_in = 16'h9876;
    step(1);
    load = 1'b0;
    chk_out("load_tick_old", 2'd1, 4'h2, 4'b0010, 1'b1);
    step(3);
    chk_out("load_tick_new", 2'd2, 4'h8, 4'b0100, 1'b1);

    // Enable dropped mid-slot for five clocks; the remaining count resumes afterwards.
    step(1);
    en = 1'b0;
    step(1);
    chk_out("dark_1clk", 2'd2, 4'h0, 4'b0000, 1'b0);
    step(4);
    chk_out("dark_5clk", 2'd2, 4'h0, 4'b0000, 1'b0);
    en = 1'b1;
    step(1);
    chk_out("resume_wait", 2'd2, 4'h0, 4'b0000, 1'b0);
    step(1);
    chk_out("resume_tick", 2'd3, 4'h9, 4'b1000, 1'b1);

    // Asynchronous reset between edges, mid-slot.
    step(1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 2'd0, 4'h0, 4'b0000, 1'b0);
    step(1);
    reset = 1'b0;
    step(2);
    chk_out("post_reset_wait", 2'd0, 4'h0, 4'b0000, 1'b0);
    step(1);
    chk_out("post_reset_tick", 2'd1, 4'h0, 4'b0010, 1'b1);

    // Three channels, one slot per clock: 1,2,0,1,... never 3.
    reset3 = 1'b0; en3 = 1'b1; load3 = 1'b1; data_in3 = 12'h321;
    for (int i = 0; i < 6; i++) begin
      step(1);
      load3 = 1'b0;
      e_oh3 = 3'b001 << exp_s[i];
      check($sformatf("n3.sel[%0d]", i), 32'(sel3), 32'(exp_s[i]));
      check($sformatf("n3.y[%0d]", i), 32'(y3), 32'(exp_y[i]));
      check($sformatf("n3.digit_en[%0d]", i), 32'(digit_en3), 32'(e_oh3));
      check($sformatf("n3.slot_tick[%0d]", i), 32'(slot_tick3), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
